pipelined_adder: RTL

- Parametrised, pipelined two's-complement adder/subtractor.
- Splits a WIDTH-bit carry chain into STAGES equal chunks, one chunk per register stage, so wide sums meet timing at one result per clock.
- Sits in the arithmetic datapath as the clocked successor to the single-bit full adder: same `a`/`b`/`cin`/`sum`/`cout` semantics, plus a valid flag, pipeline stall, subtract mode and signed-overflow detection.

---
 rtl/pipelined_adder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor, one carry chunk per stage.
// Optional macro PIPELINED_ADDER_SAT_EN clamps the sum on signed overflow.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad
        $error("pipelined_adder: illegal WIDTH/STAGES combination");
    end

    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Inversion and forced carry are applied at entry so they ride with the op.
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;

    logic [C-1:0]     fa;
    logic [C-1:0]     fb;
    logic             fc;
    logic             fv;
    logic [C:0]       fadd;
    logic [WIDTH-1:0] res;

    assign fadd = {1'b0, fa} + {1'b0, fb} + {{C{1'b0}}, fc};

    if (STAGES == 1) begin : g_one
        assign fa  = a;
        assign fb  = b_in;
        assign fc  = c_in;
        assign fv  = in_valid;
        assign res = fadd[C-1:0];
    end else begin : g_pipe
        for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
            localparam int R = WIDTH - (k + 1) * C;
            localparam int D = (k + 1) * C;

            logic         v_q, c_q, v_d;
            logic [R-1:0] a_q, b_q, a_d, b_d;
            logic [D-1:0] s_q, s_d;
            logic [C:0]   add;

            if (k == 0) begin : g_in
                assign add = {1'b0, a[C-1:0]} + {1'b0, b_in[C-1:0]}
                           + {{C{1'b0}}, c_in};
                assign v_d = in_valid;
                assign a_d = a[WIDTH-1:C];
                assign b_d = b_in[WIDTH-1:C];
                assign s_d = add[C-1:0];
            end else begin : g_mid
                assign add = {1'b0, g_st[k-1].a_q[C-1:0]}
                           + {1'b0, g_st[k-1].b_q[C-1:0]}
                           + {{C{1'b0}}, g_st[k-1].c_q};
                assign v_d = g_st[k-1].v_q;
                assign a_d = g_st[k-1].a_q[R+C-1:C];
                assign b_d = g_st[k-1].b_q[R+C-1:C];
                assign s_d = {add[C-1:0], g_st[k-1].s_q};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (en) begin
                    v_q <= v_d;
                    c_q <= add[C];
                    a_q <= a_d;
                    b_q <= b_d;
                    s_q <= s_d;
                end
            end
        end

        assign fa  = g_st[STAGES-2].a_q;
        assign fb  = g_st[STAGES-2].b_q;
        assign fc  = g_st[STAGES-2].c_q;
        assign fv  = g_st[STAGES-2].v_q;
        assign res = {fadd[C-1:0], g_st[STAGES-2].s_q};
    end

    logic             cout_d;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_d;

    assign cout_d = fadd[C];
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign ovf_d  = (fa[C-1] ^ fb[C-1] ^ res[WIDTH-1]) ^ cout_d;

`ifdef PIPELINED_ADDER_SAT_EN
    assign sum_d = ovf_d ? {fa[C-1], {(WIDTH-1){~fa[C-1]}}} : res;
`else
    assign sum_d = res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= fv;
            if (fv) begin
                sum  <= sum_d;
                cout <= cout_d;
                ovf  <= ovf_d;
            end
        end
    end

endmodule
